// File: rtl/alu_result_skid.sv
// alu_result_skid: two-entry registered skid stage for ALU results; ALU_STICKY_OVF_EN adds ovf_sticky/ovf_clr
module alu_result_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carryout,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             out_zero
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic             ovf_sticky,
  input  logic             ovf_clr
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [WIDTH+2:0] head, skid, in_entry;
  logic push, pop, load_in, load_skid, load_from_skid;
  assign in_entry = {in_result, in_carryout, in_overflow, ~|in_result};
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign {out_result, out_carryout, out_overflow, out_zero} = head;
  always_comb begin
    state_n = state;
    load_in = 1'b0;
    load_skid = 1'b0;
    load_from_skid = 1'b0;
    state_n = state == EMPTY ? (push ? ONE : EMPTY) :
              state == ONE ? ((push && !pop) ? FULL : (!push && pop) ? EMPTY : ONE) :
              (pop ? ONE : FULL);
    load_in = push && (state == EMPTY || (state == ONE && pop));
    load_skid = push && state == ONE && !pop;
    load_from_skid = state == FULL && pop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      head <= '0;
      skid <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n != FULL;
      if (load_in) head <= in_entry;
      else if (load_from_skid) head <= skid;
      if (load_skid) skid <= in_entry;
    end
  end
`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (reset) ovf_sticky <= 1'b0;
    else ovf_sticky <= (push && in_overflow) ? 1'b1 : ovf_clr ? 1'b0 : ovf_sticky;
  end
`endif
endmodule

// File: tb/tb_alu_result_skid.sv
// tb_alu_result_skid: directed table plus streaming scoreboard for alu_result_skid
module tb_alu_result_skid;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_carryout, in_overflow;
  logic out_valid, out_ready, out_carryout, out_overflow, out_zero;
  logic [31:0] in_result, out_result;
`ifdef ALU_STICKY_OVF_EN
  logic ovf_sticky, ovf_clr;
`endif
  int checks = 0;
  int failures = 0;
  alu_result_skid #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carryout(in_carryout), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carryout(out_carryout), .out_overflow(out_overflow), .out_zero(out_zero)
`ifdef ALU_STICKY_OVF_EN
    , .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, iv, co, ovf, ordy;
    logic [31:0] res;
    logic e_ov, e_ir, e_co, e_ovf, e_z;
    logic [31:0] e_res;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] exp_next;
    logic [31:0] prev_res;
    logic stall_prev;
    int cnt, recv, sent, cyc;
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_carryout = 1'b0; in_overflow = 1'b0; out_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    //        rst iv co ovf ordy res            ov ir co ovf z  e_res
    v[0]  = '{1, 0, 0, 0, 1, 32'h0,          0, 1, 0, 0, 0, 32'h0};
    v[1]  = '{1, 0, 0, 0, 1, 32'h0,          0, 1, 0, 0, 0, 32'h0};
    v[2]  = '{0, 0, 0, 0, 1, 32'h0,          0, 1, 0, 0, 0, 32'h0};
    v[3]  = '{0, 1, 0, 1, 1, 32'h7FFFFFFF,   1, 1, 0, 1, 0, 32'h7FFFFFFF};
    v[4]  = '{0, 0, 0, 0, 1, 32'h0,          0, 1, 0, 1, 0, 32'h7FFFFFFF};
    v[5]  = '{0, 1, 1, 0, 0, 32'h0,          1, 1, 1, 0, 1, 32'h0};
    v[6]  = '{0, 1, 0, 0, 0, 32'h1,          1, 0, 1, 0, 1, 32'h0};
    v[7]  = '{0, 1, 0, 1, 0, 32'h2,          1, 0, 1, 0, 1, 32'h0};
    v[8]  = '{0, 0, 0, 0, 1, 32'h0,          1, 1, 0, 0, 0, 32'h1};
    v[9]  = '{0, 0, 0, 0, 1, 32'h0,          0, 1, 0, 0, 0, 32'h1};
    v[10] = '{0, 1, 0, 1, 0, 32'hA,          1, 1, 0, 1, 0, 32'hA};
    v[11] = '{0, 1, 0, 0, 0, 32'hB,          1, 0, 0, 1, 0, 32'hA};
    v[12] = '{1, 0, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0};
    v[13] = '{0, 1, 1, 0, 0, 32'h5,          1, 1, 1, 0, 0, 32'h5};
    v[14] = '{0, 0, 0, 0, 1, 32'h0,          0, 1, 1, 0, 0, 32'h5};
    for (int i = 0; i < 15; i++) begin
      reset = v[i].rst; in_valid = v[i].iv; in_carryout = v[i].co;
      in_overflow = v[i].ovf; out_ready = v[i].ordy; in_result = v[i].res;
      step();
      chk($sformatf("vec%0d {valid,ready,co,ovf,zero,result}", i),
          {27'b0, out_valid, in_ready, out_carryout, out_overflow, out_zero, out_result},
          {27'b0, v[i].e_ov, v[i].e_ir, v[i].e_co, v[i].e_ovf, v[i].e_z, v[i].e_res});
    end
    reset = 1'b0; in_carryout = 1'b0; in_overflow = 1'b0;
    cnt = 0; recv = 0; sent = 0; cyc = 0; stall_prev = 1'b0; prev_res = '0;
    while (recv < 100 && cyc < 1000) begin
      in_valid = sent < 100;
      in_result = sent + 1;
      out_ready = (cyc % 2) == 0;
      #1;
      chk("stream in_ready", {63'b0, in_ready}, {63'b0, cnt < 2});
      chk("stream out_valid", {63'b0, out_valid}, {63'b0, cnt > 0});
      if (stall_prev) chk("stream stall hold", {32'b0, out_result}, {32'b0, prev_res});
      if (out_valid && out_ready) begin
        exp_next = recv + 1;
        chk("stream order", {32'b0, out_result}, {32'b0, exp_next});
        recv++; cnt--;
      end
      if (in_valid && in_ready) begin
        sent++; cnt++;
      end
      stall_prev = out_valid && !out_ready;
      prev_res = out_result;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream received count", 64'(recv), 64'd100);
`ifdef ALU_STICKY_OVF_EN
    out_ready = 1'b1;
    reset = 1'b1; step(); reset = 1'b0;
    chk("sticky after reset", {63'b0, ovf_sticky}, 64'd0);
    in_valid = 1'b1; in_result = 32'h80000000; in_overflow = 1'b1; step();
    chk("sticky set", {63'b0, ovf_sticky}, 64'd1);
    in_result = 32'h3; in_overflow = 1'b0; step(); step();
    chk("sticky holds", {63'b0, ovf_sticky}, 64'd1);
    in_overflow = 1'b1; ovf_clr = 1'b1; step();
    chk("sticky set beats clr", {63'b0, ovf_sticky}, 64'd1);
    in_valid = 1'b0; in_overflow = 1'b0; step();
    chk("sticky clr", {63'b0, ovf_sticky}, 64'd0);
    ovf_clr = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
